// File: rtl/sr_arb_pkg.sv
// -----------------------------------------------------------------------------
// sr_arb_pkg
// Shared types and constants for the SR flag arbiter slice.
//   state_t      : arbiter FSM states (IDLE, GRANT)
//   MAX_N        : largest supported requester count
//   SR_SET/CLR/HOLD and sr_cmd() : decoded per-flag set/reset command
// -----------------------------------------------------------------------------
package sr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int MAX_N = 16;

  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_SET  = 2'b01;
  localparam logic [1:0] SR_CLR  = 2'b10;

  // s=1,r=1 deliberately decodes to HOLD: the illegal SR pair never clears.
  function automatic logic [1:0] sr_cmd(input logic s, input logic r);
    logic [1:0] cmd;
    cmd = SR_HOLD;
    if (s && !r) cmd = SR_SET;
    else if (!s && r) cmd = SR_CLR;
    return cmd;
  endfunction

endpackage

// File: rtl/sr_rr_pick.sv
// -----------------------------------------------------------------------------
// sr_rr_pick
// Purely combinational round-robin picker. Searches pend starting at
// last_id+1 and wrapping modulo N; reports the first set index.
// Ports:
//   pend    in  N    pending flags
//   last_id in  IDW  most recently served index
//   found   out 1    at least one flag pending
//   pick_id out IDW  chosen index (0 when nothing is found)
// -----------------------------------------------------------------------------
module sr_rr_pick
  import sr_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   pend,
  input  logic [IDW-1:0] last_id,
  output logic           found,
  output logic [IDW-1:0] pick_id
);

  // Index increment with explicit wrap so non-power-of-2 N never escapes 0..N-1.
  function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] v);
    logic [IDW-1:0] nv;
    if (v == IDW'(N - 1)) nv = '0;
    else nv = v + IDW'(1);
    return nv;
  endfunction

  // Walk N positions from last_id+1; the first hit wins.
  always_comb begin
    logic [IDW-1:0] idx;
    found   = 1'b0;
    pick_id = '0;
    idx     = inc_wrap(last_id);
    for (int k = 0; k < N; k++) begin
      if (!found && pend[idx]) begin
        found   = 1'b1;
        pick_id = idx;
      end
      idx = inc_wrap(idx);
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// -----------------------------------------------------------------------------
// sr_flag_arbiter
// Bank of N SR pending flags with a round-robin grant to one shared resource
// over a valid/ready handshake. A served flag is cleared on the handshake.
// Optional feature macro: SR_ARB_LOCK_EN (adds the 'lock' input that lets a
// re-set granted requester keep the grant back-to-back without a bubble).
// Ports:
//   clk       in  1    rising-edge clock
//   rst       in  1    synchronous active-high reset
//   s, r      in  N    per-requester set / reset
//   gnt_ready in  1    resource accepts the current grant
//   lock      in  1    (SR_ARB_LOCK_EN only) hold grant on re-set requester
//   gnt_valid out 1    grant offered
//   gnt_id    out IDW  granted requester index
//   pend      out N    pending flags
//   busy      out 1    high while in GRANT
// -----------------------------------------------------------------------------
module sr_flag_arbiter
  import sr_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   s,
  input  logic [N-1:0]   r,
  input  logic           gnt_ready,
`ifdef SR_ARB_LOCK_EN
  input  logic           lock,
`endif
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic [N-1:0]   pend,
  output logic           busy
);

  state_t         state_q, state_d;
  logic [IDW-1:0] last_id, last_id_d;
  logic [IDW-1:0] gnt_id_d;
  logic [N-1:0]   pend_d;
  logic           handshake;
  logic           lock_keep;
  logic           found;
  logic [IDW-1:0] pick_id;

  sr_rr_pick #(.N(N)) u_pick (
    .pend    (pend),
    .last_id (last_id),
    .found   (found),
    .pick_id (pick_id)
  );

  assign gnt_valid = (state_q == GRANT);
  assign busy      = (state_q == GRANT);
  assign handshake = gnt_valid & gnt_ready;

  // Next pending flags: SR update per bit, then the handshake clears the
  // served flag unless that requester is setting again in the same cycle.
  always_comb begin
    pend_d = pend;
    for (int i = 0; i < N; i++) begin
      case (sr_cmd(s[i], r[i]))
        SR_SET:  pend_d[i] = 1'b1;
        SR_CLR:  pend_d[i] = 1'b0;
        default: pend_d[i] = pend[i];
      endcase
    end
    if (handshake && (sr_cmd(s[gnt_id], r[gnt_id]) != SR_SET))
      pend_d[gnt_id] = 1'b0;
  end

`ifdef SR_ARB_LOCK_EN
  assign lock_keep = lock & pend_d[gnt_id];
`else
  assign lock_keep = 1'b0;
`endif

  // FSM next state. IDLE picks from the registered flags, so every
  // normal grant costs one bubble cycle.
  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id;
    last_id_d = last_id;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_id_d = pick_id;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (handshake && !lock_keep) begin
          last_id_d = gnt_id;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, flags and grant registers; reset drops any outstanding grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend    <= '0;
      gnt_id  <= '0;
      last_id <= IDW'(N - 1);
    end else begin
      state_q <= state_d;
      pend    <= pend_d;
      gnt_id  <= gnt_id_d;
      last_id <= last_id_d;
    end
  end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sr_flag_arbiter
// Directed and random stimulus against a behavioural model of sr_flag_arbiter.
// Honours SR_ARB_LOCK_EN when defined.
// -----------------------------------------------------------------------------
module tb_sr_flag_arbiter;

  localparam int N   = 4;
  localparam int IDW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   s, r;
  logic           gnt_ready;
`ifdef SR_ARB_LOCK_EN
  logic           lock;
`endif
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic [N-1:0]   pend;
  logic           busy;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit     m_pend [N];
  bit     m_granted;
  int     m_gid;
  int     m_last;

  sr_flag_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (s),
    .r         (r),
    .gnt_ready (gnt_ready),
`ifdef SR_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .pend      (pend),
    .busy      (busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [N-1:0] model_pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // One-cycle step of the model, written from the behavioural rules
  task automatic model_step(input logic rst_in, input logic [N-1:0] s_in,
                            input logic [N-1:0] r_in, input logic rdy_in,
                            input logic lock_in);
    bit nxt [N];
    bit hs;
    if (rst_in) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_granted = 0;
      m_gid     = 0;
      m_last    = N - 1;
    end else begin
      hs = m_granted && rdy_in;
      for (int i = 0; i < N; i++) begin
        if (s_in[i] && !r_in[i]) nxt[i] = 1;
        else if (!s_in[i] && r_in[i]) nxt[i] = 0;
        else nxt[i] = m_pend[i];
      end
      if (hs && !(s_in[m_gid] && !r_in[m_gid])) nxt[m_gid] = 0;
      if (!m_granted) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_last + 1 + k) % N;
          if (!m_granted && m_pend[idx]) begin
            m_granted = 1;
            m_gid     = idx;
          end
        end
      end else if (hs) begin
        if (!(lock_in && nxt[m_gid])) begin
          m_granted = 0;
          m_last    = m_gid;
        end
      end
      for (int i = 0; i < N; i++) m_pend[i] = nxt[i];
    end
  endtask

  // Compare every DUT output with the model
  task automatic checkOutput(input string tag);
    logic [N-1:0] ep;
    ep = model_pend_vec();
    checks++;
    assert (gnt_valid === m_granted) else begin
      errors++;
      $error("[TB] FAIL %s gnt_valid observed=%0b expected=%0b", tag, gnt_valid, m_granted);
    end
    checks++;
    assert (busy === m_granted) else begin
      errors++;
      $error("[TB] FAIL %s busy observed=%0b expected=%0b", tag, busy, m_granted);
    end
    checks++;
    assert (gnt_id === IDW'(m_gid)) else begin
      errors++;
      $error("[TB] FAIL %s gnt_id observed=%0d expected=%0d", tag, gnt_id, m_gid);
    end
    checks++;
    assert (pend === ep) else begin
      errors++;
      $error("[TB] FAIL %s pend observed=%b expected=%b", tag, pend, ep);
    end
  endtask

  // Drive one cycle of inputs away from the edge, advance model, then check
  task automatic applyStimulus(input string tag, input logic rst_in,
                               input logic [N-1:0] s_in, input logic [N-1:0] r_in,
                               input logic rdy_in, input logic lock_in);
    logic eff_lock;
    @(negedge clk);
    rst       = rst_in;
    s         = s_in;
    r         = r_in;
    gnt_ready = rdy_in;
`ifdef SR_ARB_LOCK_EN
    lock      = lock_in;
    eff_lock  = lock_in;
`else
    eff_lock  = 1'b0;
    if (lock_in) eff_lock = 1'b0;
`endif
    model_step(rst_in, s_in, r_in, rdy_in, eff_lock);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  // Literal check of a single value against a hand-derived expectation
  task automatic checkLiteral(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; s = '0; r = '0; gnt_ready = 1'b0;
`ifdef SR_ARB_LOCK_EN
    lock = 1'b0;
`endif
    m_granted = 0; m_gid = 0; m_last = N - 1;
    for (int i = 0; i < N; i++) m_pend[i] = 0;

    // Reset state
    applyStimulus("reset", 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    applyStimulus("reset", 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0);
    checkLiteral("reset_pend", 32'(pend), 32'h0);
    checkLiteral("reset_valid", 32'(gnt_valid), 32'h0);

    // Reset mid-grant
    applyStimulus("midrst_set", 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0);
    applyStimulus("midrst_grant", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    checkLiteral("midrst_valid", 32'(gnt_valid), 32'h1);
    applyStimulus("midrst_hold", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    applyStimulus("midrst_rst", 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    checkLiteral("midrst_drop", 32'({gnt_valid, busy, pend}), 32'h0);
    applyStimulus("midrst_set1", 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0);
    applyStimulus("midrst_grant1", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    checkLiteral("midrst_gid1", 32'({gnt_valid, gnt_id}), 32'h5);
    applyStimulus("midrst_done", 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);

    // Round-robin fairness: 0,1,2,3 one grant every two cycles
    applyStimulus("rr_rst", 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    applyStimulus("rr_set", 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b0);
    for (int j = 0; j < N; j++) begin
      applyStimulus("rr_grant", 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
      checkLiteral("rr_gid", 32'({gnt_valid, gnt_id}), 32'(4 + j));
      applyStimulus("rr_hs", 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
      checkLiteral("rr_bubble", 32'(gnt_valid), 32'h0);
    end
    checkLiteral("rr_pend_end", 32'(pend), 32'h0);

    // SR semantics on index 2
    applyStimulus("sr_rst", 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    applyStimulus("sr_both0", 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0);
    checkLiteral("sr_hold0", 32'(pend[2]), 32'h0);
    applyStimulus("sr_set", 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0);
    checkLiteral("sr_set", 32'(pend[2]), 32'h1);
    applyStimulus("sr_both1", 1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0);
    checkLiteral("sr_hold1", 32'(pend[2]), 32'h1);
    applyStimulus("sr_clr", 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0);
    checkLiteral("sr_clr", 32'(pend[2]), 32'h0);

    // Withdrawal during grant
    applyStimulus("wd_rst", 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    applyStimulus("wd_set", 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0);
    applyStimulus("wd_grant", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    applyStimulus("wd_clr", 1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0);
    checkLiteral("wd_stable", 32'({gnt_valid, gnt_id, pend}), 32'h50);
    applyStimulus("wd_hs", 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    checkLiteral("wd_idle", 32'(gnt_valid), 32'h0);

    // Re-set on handshake: requester 0 re-queued behind 1
    applyStimulus("rs_rst", 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    applyStimulus("rs_set", 1'b0, 4'b0011, 4'b0000, 1'b0, 1'b0);
    applyStimulus("rs_grant0", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
    applyStimulus("rs_hs", 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0);
    checkLiteral("rs_pend", 32'({gnt_valid, pend}), 32'h03);
    applyStimulus("rs_grant1", 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    checkLiteral("rs_gid1", 32'({gnt_valid, gnt_id}), 32'h5);
    applyStimulus("rs_hs1", 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    applyStimulus("rs_grant0b", 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    checkLiteral("rs_gid0", 32'({gnt_valid, gnt_id}), 32'h4);
    applyStimulus("rs_hs0", 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);

`ifdef SR_ARB_LOCK_EN
    // Lock: back-to-back grants to index 3, then rotate on release
    applyStimulus("lk_rst", 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    applyStimulus("lk_set", 1'b0, 4'b1001, 4'b0000, 1'b0, 1'b1);
    applyStimulus("lk_grant0", 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0);
    applyStimulus("lk_hs0", 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b0);
    applyStimulus("lk_grant3", 1'b0, 4'b1001, 4'b0000, 1'b1, 1'b1);
    for (int j = 0; j < 3; j++) begin
      applyStimulus("lk_b2b", 1'b0, 4'b1000, 4'b0000, 1'b1, 1'b1);
      checkLiteral("lk_b2b_gid", 32'({gnt_valid, gnt_id}), 32'h7);
    end
    applyStimulus("lk_release", 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    applyStimulus("lk_next", 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    checkLiteral("lk_next_gid", 32'({gnt_valid, gnt_id}), 32'h4);
`endif

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic          rr_rst;
      logic [N-1:0]  rs, rrv;
      rr_rst = ($urandom_range(0, 59) == 0);
      rs     = N'($urandom) & N'($urandom);
      rrv    = N'($urandom) & N'($urandom) & N'($urandom);
      applyStimulus("random", rr_rst, rs, rrv, 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
- Bank of N SR-style pending flags, one per requester. Each flag has a set/reset input pair with the same set/reset/hold semantics as the team's SR flip-flops.
- A round-robin scheduler grants one pending flag at a time to a single shared downstream resource over a valid/ready handshake. The granted flag is cleared when the handshake completes.
- Sits between requester-side SR control lines and the shared resource.

Parameters:
- N, 4, number of requesters (2..16).
- IDW, $clog2(N), width of the grant index (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- s  input  N  per-requester set.
- r  input  N  per-requester reset.
- gnt_ready  input  1  resource accepts the current grant.
- gnt_valid  output  1  grant offered.
- gnt_id  output  IDW  index of the granted requester.
- pend  output  N  current pending flags.
- busy  output  1  high while in the GRANT state.

Behaviour:
- Reset (rst=1 at posedge clk): pend=0, gnt_valid=0, gnt_id=0, busy=0, state=IDLE, last_id=N-1 so the first search starts at index 0. Reset overrides all other inputs, including in mid-grant. An outstanding grant is dropped without completing its handshake.
- Per-flag SR update, evaluated each posedge:
  - s=1, r=0 → set.
  - s=0, r=1 → clear.
  - s=0, r=0 → hold.
  - s=1, r=1 → hold (the illegal SR combination is held, never cleared).
- States:
  - IDLE: gnt_valid=0. If any pend bit is 1, pick the first set bit searching from last_id+1 upward, wrapping modulo N. Register that index into gnt_id and go to GRANT. Otherwise stay in IDLE.
  - GRANT: gnt_valid=1, busy=1. gnt_id is stable until the handshake.
    - Handshake = gnt_valid & gnt_ready at a posedge. On the handshake: clear pend[gnt_id], set last_id=gnt_id, return to IDLE.
    - IDLE always costs one bubble cycle between grants (maximum one grant per 2 cycles).
- Latency: s pulse at edge t → pend visible after t → gnt_valid high after edge t+1. Two cycles from the set edge to grant visible.
- Boundary rules:
  - r on the granted index while in GRANT: the grant is not withdrawn. pend[gnt_id] shows 0, but gnt_valid and gnt_id stay until the handshake.
  - s (with r=0) on the granted index in the handshake cycle: set wins. pend stays 1, so the requester is re-queued and is served after the others by round-robin.
  - s/r on non-granted indices apply normally in every state.
  - Wrap-around: with last_id=N-1, the search starts at index 0.
  - gnt_ready while in IDLE is ignored.
- No arithmetic beyond the IDW-bit modulo-N index increment. For non-power-of-2 N, an index of N wraps to 0.

Optional Feature:
- Macro: SR_ARB_LOCK_EN.
- With the macro defined:
  - Extra input port lock (1 bit).
  - When a handshake occurs while lock=1, the FSM returns directly to GRANT with the same gnt_id, provided pend[gnt_id] is still 1 (re-set in that cycle). There is no bubble and no rotation, and last_id is unchanged.
  - If pend[gnt_id] is not still 1, normal behaviour applies.
- Without the macro: no lock port; behaviour exactly as above.

Decomposition:
- Package sr_arb_pkg:
  - state enum {IDLE, GRANT}.
  - localparam for the maximum N (16).
  - SR command encoding constants (SET, CLR, HOLD).
- One sub-module, sr_rr_pick: purely combinational round-robin picker.
  - Inputs: pend, last_id.
  - Outputs: found, pick_id.
- The top level holds the pend register bank, the FSM, last_id, and the grant registers.

Test Plan:
- Reset mid-grant: N=4, pulse s=0001, wait for gnt_valid with gnt_ready=0, assert rst → next edge gnt_valid=0, pend=0000, busy=0; then s=0010 → gnt_id=1 two cycles later.
- Round-robin fairness: s=1111 in one cycle, gnt_ready=1 always → gnt_id sequence 0,1,2,3, one grant every 2 cycles, pend ends at 0000.
- SR semantics: on idx 2, drive s=1,r=1 → pend[2] holds 0; then s=1,r=0 → 1; then s=1,r=1 → holds 1; then s=0,r=1 → 0.
- Withdrawal during grant: grant idx 1 with gnt_ready=0, pulse r[1] → pend[1]=0 while gnt_valid=1, gnt_id=1 stay stable; gnt_ready=1 → handshake, then IDLE.
- Re-set on handshake: pend=0011, gnt_id=0, assert s[0] in the handshake cycle → pend=0011 after; next grant gnt_id=1, then gnt_id=0.
- SR_ARB_LOCK_EN: lock=1, s[3] held high, grant idx 3 → consecutive handshakes every cycle with gnt_id=3 and no IDLE bubble; drop lock → next grant idx 0 if pending.
